add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin an operation
- sub  in  1  1 = a - b, 0 = a + b + cin
- cin  in  1  carry-in for add; ignored when sub=1
- a  in  32  operand A
- b  in  32  operand B
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- sum  out  32  result
- cout  out  1  carry out of bit 31
- ovf  out  1  signed overflow

Function
REQ-003 The block SHALL compute the 32-bit result by sharing a single 4-bit carry-lookahead slice over 8 consecutive cycles, nibble 0 (bits 3:0) first.
- slice p = a_n ^ b_n
- slice g = a_n & b_n
- carries c1..c3 and the slice carry-out use standard CLA equations.
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE: start=1 goes to RUN.
- RUN: stays in RUN until the nibble counter equals 7, then goes to DONE.
- DONE: start=1 goes to RUN; otherwise goes to IDLE.
REQ-005 A start accepted in IDLE or DONE SHALL latch a, b, sub and cin on the same edge, clear the 3-bit nibble counter, and clear sum.
REQ-006 When sub=1, the operand latch SHALL store ~b, and the initial carry SHALL be forced to 1.
REQ-007 When sub=0, the initial carry SHALL equal cin.
REQ-008 Each RUN cycle SHALL process exactly one nibble.
- write sum[4k+3:4k] for nibble k
- register the slice carry-out as the carry-in for nibble k+1
- increment the counter
REQ-009 The counter SHALL wrap from 7 to 0 on the RUN-to-DONE transition.
REQ-010 busy SHALL be 1 exactly while the state is RUN.
REQ-011 done SHALL be 1 exactly while the state is DONE, which is the 9th cycle after the accepting edge, and SHALL last one cycle.
REQ-012 Latency from the start-accepting edge to done high SHALL be 9 clock edges.
REQ-013 Throughput SHALL be one operation per 9 cycles when start is held high.
REQ-014 cout SHALL equal the nibble-7 slice carry-out.
REQ-015 ovf SHALL equal the carry into bit 31 XOR the carry out of bit 31.
REQ-016 cout and ovf SHALL be updated on the same edge that writes nibble 7.
REQ-017 sum, cout and ovf SHALL hold their values from done until the next accepted start.
REQ-018 start while busy=1 SHALL be ignored: no state, operand or result change.
REQ-019 start asserted in the same cycle as done=1 SHALL be accepted.
- done falls on the next edge.
- busy rises on the next edge.
- The new operands are latched on that edge.
REQ-020 Changes on a, b, sub or cin while busy=1 SHALL NOT affect the result in progress.

Reset
REQ-021 When rst_n=0, the block SHALL asynchronously force:
- state = IDLE
- counter = 0
- carry register = 0
- operand latches = 0
- busy = 0, done = 0
- sum = 0, cout = 0, ovf = 0
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-023 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- V1: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0, one-cycle start -> busy high 8 cycles, done at cycle 9, sum=0x00000000, cout=1, ovf=0.
- V2: a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- V3: a=0x00000005, b=0x00000007, sub=1 (cin=1 ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
- V4: start with a=0x12345678, b=0x11111111; at RUN cycle 3, pulse start with a=0, b=0 and also change a/b -> sum=0x23456789, only one done pulse.
- V5: rst_n=0 during RUN cycle 4 -> busy, done, sum, cout and ovf all 0 immediately with no done pulse; then start with a=3, b=4 -> sum=0x00000007 at cycle 9.
- V6: start held high for two operations, (1+2) then (0x80000000+0x80000000) -> done at cycles 9 and 18, sum=0x00000003 then sum=0x00000000 with cout=1 and ovf=1, busy low only during each done cycle.
REQ-025 The bench SHALL also compare against a 33-bit reference sum over 2000 random cycles with random start, sub and cin, flagging any mismatch in sum, cout or ovf at done.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Sequential 32-bit adder/subtractor: one shared 4-bit carry-lookahead slice
// processes a nibble per cycle, LSB nibble first, over 8 RUN cycles.
module add_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic        cin,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        carry;
  logic [31:0] a_q, b_q;
  logic [3:0]  an, bn, p, g, nib;
  logic        c1, c2, c3, c4;
  logic        accept;

  // Handshake: start is sampled on a rising edge and takes effect only when
  // the block is not busy (IDLE or DONE); while busy it is ignored.
  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == 3'd7) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shared CLA slice operating on nibble cnt of the latched operands.
  always_comb begin
    an  = a_q[{cnt, 2'b00} +: 4];
    bn  = b_q[{cnt, 2'b00} +: 4];
    p   = an ^ bn;
    g   = an & bn;
    c1  = g[0] | (p[0] & carry);
    c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
        | (p[3] & p[2] & p[1] & p[0] & carry);
    nib = p ^ {c3, c2, c1, carry};
  end

  // Subtraction is folded into the latch: a - b = a + ~b + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 3'd0;
      carry <= 1'b0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sum   <= 32'd0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= 3'd0;
      sum   <= 32'd0;
    end else if (state == RUN) begin
      sum[{cnt, 2'b00} +: 4] <= nib;
      carry <= c4;
      cnt   <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        cout <= c4;
        ovf  <= c3 ^ c4;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: directed scenarios with literal expectations plus
// random traffic checked every cycle against a cycle-count / 33-bit model.
module tb_add_seq_ctrl;

  logic        clk, rst_n, start, sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  int checks   = 0;
  int failures = 0;
  int rnd_done = 0;
  bit chk_en   = 0;

  add_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..8 busy cycles, 9 done cycle.
  int          m_phase;
  logic [31:0] m_sum;
  logic        m_cout, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if ((m_phase == 0 || m_phase == 9) && start) begin
      logic [31:0] be;
      logic [32:0] r;
      be = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
      m_phase <= 1;
      m_sum   <= r[31:0];
      m_cout  <= r[32];
      m_ovf   <= (a[31] == be[31]) && (r[31] != a[31]);
    end else if (m_phase >= 1 && m_phase <= 8) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == 9) begin
      m_phase <= 0;
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, (m_phase >= 1 && m_phase <= 8)});
      check("done", {31'd0, done}, {31'd0, (m_phase == 9)});
      if (m_phase == 0 || m_phase == 9) begin
        check("sum_hold", sum, m_sum);
        check("cout_hold", {31'd0, cout}, {31'd0, m_cout});
        check("ovf_hold", {31'd0, ovf}, {31'd0, m_ovf});
      end
      if (m_phase == 9) rnd_done++;
    end
  end

  // driver tasks
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input logic tc, input logic [31:0] es, input logic ec,
                        input logic eo, input string nm);
    int cyc, nbusy;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
    cyc = 1; nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, 9);
    check({nm, "_busy_cycles"}, nbusy, 8);
    check({nm, "_sum"}, sum, es);
    check({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, ndone, done_cyc;
    logic [31:0] done_sum;
    rst_n = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", sum, 32'd0);
    check("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "V1");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "V2");
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "V3");

    // V4: start pulse and operand changes mid-run are ignored
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; done_cyc = 0; done_sum = '0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin ndone++; done_cyc = i; done_sum = sum; end
      if (i == 3) begin start = 1'b1; a = 32'd0; b = 32'd0; end
      if (i == 4) begin start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b1; end
      @(posedge clk); #1;
    end
    check("V4_done_count", ndone, 1);
    check("V4_done_cycle", done_cyc, 9);
    check("V4_sum", done_sum, 32'h2345_6789);

    // V5: reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("V5_busy", {31'd0, busy}, 32'd0);
    check("V5_done", {31'd0, done}, 32'd0);
    check("V5_sum", sum, 32'd0);
    check("V5_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
    check("V5_no_done", ndone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, "V5_after");

    // V6: start held high for back-to-back operations
    @(negedge clk);
    a = 32'd1; b = 32'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h8000_0000; b = 32'h8000_0000;
    cyc = 1;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("V6_first_cycle", cyc, 9);
    check("V6_first_sum", sum, 32'h0000_0003);
    @(posedge clk); #1;
    start = 1'b0;
    cyc++;
    while (!done && cyc < 30) begin @(posedge clk); #1; cyc++; end
    check("V6_second_cycle", cyc, 18);
    check("V6_second_sum", sum, 32'h0000_0000);
    check("V6_second_cout_ovf", {30'd0, cout, ovf}, 32'd3);

    // random traffic, checked by the scoreboard every cycle
    rnd_done = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      sub   = $urandom_range(0, 1);
      cin   = $urandom_range(0, 1);
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("random_done_seen", {31'd0, (rnd_done > 50)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
